cache_tag_array_nway: RTL
=========================

Name: cache_tag_array_nway

Overview:
Parametrised N-way set-associative tag store, successor to the single-way direct tag RAM. Holds tag plus valid bit per way per set and compares a lookup tag against all ways in parallel. Reports hit, hit way and a replacement victim one cycle after each lookup. Sits between the cache controller and the data arrays; the controller uses hit_way and victim_way to steer data-array access and refills.

Parameters:
AWIDTH, 3, set-index width; DEPTH = 1 << AWIDTH sets
TWIDTH, 14, stored tag width
WAYS, 2, associativity; power of two, 1..8
WWIDTH, derived = max(1, clog2(WAYS)), way-number width; localparam, not overridable

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
lookup_valid  input  1  lookup request this cycle
lookup_index  input  AWIDTH  set to look up
lookup_tag  input  TWIDTH  tag to compare
lookup_ready  output  1  high when lookups are accepted (not in INIT/FLUSH)
resp_valid  output  1  response strobe, one cycle after an accepted lookup
hit  output  1  any valid way matched; qualified by resp_valid
hit_way  output  WWIDTH  matching way; 0 on miss
victim_way  output  WWIDTH  way to refill for this set
fill_valid  input  1  write tag into a way
fill_index  input  AWIDTH  set to fill
fill_way  input  WWIDTH  way to fill
fill_tag  input  TWIDTH  tag written; valid bit set
flush  input  1  pulse: invalidate all sets
busy  output  1  INIT or FLUSH in progress

Behaviour:
- Reset and FSM:
  - Synchronous active-high reset; the clock is named clock and the reset is named reset.
  - FSM states are INIT, IDLE and FLUSH. Reset forces INIT with walk counter 0.
  - INIT and FLUSH clear the valid bits and round-robin pointer of one set per cycle, sets 0..DEPTH-1. They last exactly DEPTH cycles, then go to IDLE.
  - flush in IDLE enters FLUSH next cycle. flush during INIT or FLUSH is ignored.
  - Reset mid-FLUSH restarts INIT from set 0.
- Reset values: lookup_ready=0, busy=1, resp_valid=0, hit=0, hit_way=0, victim_way=0.
- lookup_ready = (state==IDLE). busy is its complement.
- Lookup:
  - A lookup is accepted when lookup_valid && lookup_ready.
  - Next cycle: resp_valid=1, hit = OR over ways of (valid[w] && tag[w]==lookup_tag), and hit_way = lowest matching way.
  - Lookup throughput is 1 per cycle. resp_valid is 0 for cycles without an accepted lookup; hit, hit_way and victim_way are don't-care then and are driven 0.
- Victim: lowest-numbered invalid way in the set; if all ways are valid, the set's round-robin pointer.
- Fill:
  - Accepted only in IDLE; ignored in INIT and FLUSH.
  - Writes the tag and sets valid at the clock edge.
  - If fill_way == pointer, the pointer increments modulo WAYS (wraps WAYS-1 -> 0).
- Same-cycle lookup and fill to the same set: the lookup returns the pre-fill contents (read-before-write). The fill is visible to lookups issued the following cycle.
- flush and fill in the same IDLE cycle: the fill is dropped.
- WAYS=1: hit_way and victim_way are always 0 and the pointer is unused.

Optional Feature:
CACHE_TAG_PARITY_EN
- Defined:
  - Each way stores an even-parity bit over the tag, computed on fill.
  - On lookup, a way with a parity mismatch is treated as not matching.
  - Extra output parity_err (1 bit, reset 0) pulses with resp_valid when any valid way in the looked-up set has bad parity.
  - A bad way is cleared (valid=0) in the response cycle.
- Undefined: no parity storage and no parity_err port.

Decomposition:
- Shared package cache_pkg holds:
  - state encoding enum (INIT, IDLE, FLUSH)
  - default AWIDTH/TWIDTH/WAYS constants
  - the clog2-based WWIDTH helper function
- Sub-module cache_tag_way: one way's tag/valid storage with synchronous write, registered read address and per-set clear. It is instantiated WAYS times via generate. Compare, priority encoding, pointer storage and FSM stay in the top module.

Test Plan:
- Reset, then hold reset low for 8 cycles (DEPTH=8) -> busy=1 and lookup_ready=0 for exactly 8 cycles; first lookup after that returns hit=0, victim_way=0.
- Fill set 3 way 0 tag 14'h1A2B, then lookup set 3 tag 14'h1A2B -> resp_valid=1, hit=1, hit_way=0 one cycle later; lookup with tag 14'h1A2C -> hit=0, victim_way=1.
- Fill set 5 ways 0 and 1 (pointer 0 -> 1 -> 0 after wrap), then lookup with a miss -> victim_way=0; fill way 0 -> next miss lookup gives victim_way=1.
- Same cycle: fill set 2 way 1 tag 14'h0055 and lookup set 2 tag 14'h0055 -> hit=0; repeat the lookup next cycle -> hit=1, hit_way=1.
- Populate sets 0..7, pulse flush, drive fill during FLUSH -> busy=1 for 8 cycles, fill ignored; every lookup afterwards misses.
- With CACHE_TAG_PARITY_EN: force a flipped tag bit in set 1 way 0, then lookup the matching tag -> hit=0, parity_err=1; a repeat lookup -> parity_err=0, victim_way=0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the N-way cache tag array.
//   - cache_state_e : controller states (INIT walk, IDLE service, FLUSH walk)
//   - DEF_*         : default geometry (8 sets, 14-bit tags, 2 ways)
//   - way_width()   : way-number width, never narrower than one bit
package cache_pkg;

  localparam int DEF_AWIDTH = 3;
  localparam int DEF_TWIDTH = 14;
  localparam int DEF_WAYS   = 2;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    FLUSH = 2'd2
  } cache_state_e;

  // A direct-mapped configuration still needs a 1-bit way field on the ports.
  function automatic int way_width(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/cache_tag_way.sv
// One way of the tag store: tag memory plus per-set valid bits.
// Optional feature macro: CACHE_TAG_PARITY_EN (adds a stored even-parity bit).
// Ports:
//   clock              rising-edge clock
//   wr_en/wr_index/wr_tag   synchronous tag write; sets the valid bit
//   clr_en/clr_index   synchronous valid-bit clear of one set
//   rd_index           read address, sampled every cycle
//   rd_tag/rd_valid    registered read data (contents before this edge's write)
//   rd_par             registered stored parity bit (parity builds only)
module cache_tag_way #(
  parameter int AWIDTH = 3,
  parameter int TWIDTH = 14
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_index,
  input  logic [TWIDTH-1:0] wr_tag,
  input  logic              clr_en,
  input  logic [AWIDTH-1:0] clr_index,
  input  logic [AWIDTH-1:0] rd_index,
  output logic [TWIDTH-1:0] rd_tag,
`ifdef CACHE_TAG_PARITY_EN
  output logic              rd_par,
`endif
  output logic              rd_valid
);

  localparam int DEPTH = 1 << AWIDTH;

  // NOTE: storage has no reset; the owner walks every set clear after reset,
  // which keeps the tag array mappable onto RAM without a reset port.
  logic [TWIDTH-1:0] tag_mem [DEPTH];
  logic [DEPTH-1:0]  valid_q;

  // NOTE: sequential state uses non-blocking assignments so the read below
  // returns the contents from before a same-edge write (read-before-write).
  always_ff @(posedge clock) begin
    if (wr_en) tag_mem[wr_index] <= wr_tag;
    rd_tag <= tag_mem[rd_index];
  end

  // A write to the set being cleared wins, so a refill is never lost.
  always_ff @(posedge clock) begin
    if (clr_en) valid_q[clr_index] <= 1'b0;
    if (wr_en)  valid_q[wr_index]  <= 1'b1;
    rd_valid <= valid_q[rd_index];
  end

`ifdef CACHE_TAG_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) par_mem[wr_index] <= ^wr_tag;
    rd_par <= par_mem[rd_index];
  end
`endif

endmodule

// File: rtl/cache_tag_array_nway.sv
// N-way set-associative tag store with parallel compare and victim choice.
// Optional feature macro: CACHE_TAG_PARITY_EN (per-way tag parity, parity_err).
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   lookup_valid/index/tag    lookup request; accepted when lookup_ready
//   lookup_ready, busy        IDLE vs. INIT/FLUSH walk in progress
//   resp_valid, hit, hit_way, victim_way   response one cycle after a lookup
//   fill_valid/index/way/tag  tag refill, accepted only in IDLE without flush
//   flush                     pulse in IDLE: invalidate every set
//   parity_err                bad stored parity seen in the looked-up set
module cache_tag_array_nway
  import cache_pkg::*;
#(
  parameter int  AWIDTH = DEF_AWIDTH,
  parameter int  TWIDTH = DEF_TWIDTH,
  parameter int  WAYS   = DEF_WAYS,
  localparam int WWIDTH = way_width(WAYS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              lookup_valid,
  input  logic [AWIDTH-1:0] lookup_index,
  input  logic [TWIDTH-1:0] lookup_tag,
  output logic              lookup_ready,
  output logic              resp_valid,
  output logic              hit,
  output logic [WWIDTH-1:0] hit_way,
  output logic [WWIDTH-1:0] victim_way,
  input  logic              fill_valid,
  input  logic [AWIDTH-1:0] fill_index,
  input  logic [WWIDTH-1:0] fill_way,
  input  logic [TWIDTH-1:0] fill_tag,
  input  logic              flush,
`ifdef CACHE_TAG_PARITY_EN
  output logic              parity_err,
`endif
  output logic              busy
);

  localparam int DEPTH = 1 << AWIDTH;

  cache_state_e      state, state_nxt;
  logic [AWIDTH-1:0] walk_idx, walk_nxt;
  logic              walk_active, lookup_acc, fill_acc;

  assign walk_active  = (state != IDLE);
  assign lookup_ready = (state == IDLE);
  assign busy         = walk_active;
  assign lookup_acc   = lookup_valid && lookup_ready;
  // A flush in the same cycle drops the fill; it would be wiped anyway.
  assign fill_acc     = fill_valid && (state == IDLE) && !flush;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= INIT;
      walk_idx <= '0;
    end else begin
      state    <= state_nxt;
      walk_idx <= walk_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no latches.
  always_comb begin
    state_nxt = state;
    walk_nxt  = walk_idx;
    unique case (state)
      INIT, FLUSH: begin
        if (walk_idx == AWIDTH'(DEPTH - 1)) begin
          state_nxt = IDLE;
          walk_nxt  = '0;
        end else begin
          walk_nxt = walk_idx + 1'b1;
        end
      end
      IDLE: begin
        if (flush) begin
          state_nxt = FLUSH;
          walk_nxt  = '0;
        end
      end
      default: begin
        state_nxt = INIT;
        walk_nxt  = '0;
      end
    endcase
  end

  // Response-side copies of the request. Only resp_q needs a reset: the rest
  // is ignored while resp_q is low.
  logic              resp_q;
  logic [TWIDTH-1:0] tag_q;
  logic [WWIDTH-1:0] ptr_q;

  always_ff @(posedge clock) begin
    if (reset) resp_q <= 1'b0;
    else       resp_q <= lookup_acc;
    tag_q <= lookup_tag;
  end

  logic [TWIDTH-1:0] rd_tag [WAYS];
  logic [WAYS-1:0]   rd_valid, way_bad, way_match, way_clr;
  logic [AWIDTH-1:0] clr_index;

`ifdef CACHE_TAG_PARITY_EN
  logic [WAYS-1:0]   rd_par;
  logic [AWIDTH-1:0] index_q;

  always_ff @(posedge clock) index_q <= lookup_index;

  always_comb begin
    way_bad = '0;
    for (int w = 0; w < WAYS; w++)
      way_bad[w] = resp_q && rd_valid[w] && ((^rd_tag[w]) != rd_par[w]);
  end

  assign parity_err = |way_bad;
  // The init/flush walk owns the clear port; a bad way found while a flush
  // starts is wiped by that flush anyway.
  assign way_clr    = walk_active ? {WAYS{1'b1}} : way_bad;
  assign clr_index  = walk_active ? walk_idx : index_q;
`else
  assign way_bad   = '0;
  assign way_clr   = {WAYS{walk_active}};
  assign clr_index = walk_idx;
`endif

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_tag_way #(
      .AWIDTH (AWIDTH),
      .TWIDTH (TWIDTH)
    ) u_way (
      .clock     (clock),
      .wr_en     (fill_acc && (fill_way == WWIDTH'(w))),
      .wr_index  (fill_index),
      .wr_tag    (fill_tag),
      .clr_en    (way_clr[w]),
      .clr_index (clr_index),
      .rd_index  (lookup_index),
      .rd_tag    (rd_tag[w]),
`ifdef CACHE_TAG_PARITY_EN
      .rd_par    (rd_par[w]),
`endif
      .rd_valid  (rd_valid[w])
    );
  end

  // Round-robin pointer per set, used only once every way is valid.
  if (WAYS > 1) begin : g_rr
    logic [WWIDTH-1:0] rr_ptr [DEPTH];

    always_ff @(posedge clock) begin
      if (walk_active)
        rr_ptr[walk_idx] <= '0;
      else if (fill_acc && (fill_way == rr_ptr[fill_index]))
        rr_ptr[fill_index] <= (rr_ptr[fill_index] == WWIDTH'(WAYS - 1)) ?
                              '0 : rr_ptr[fill_index] + 1'b1;
      ptr_q <= rr_ptr[lookup_index];
    end
  end else begin : g_no_rr
    assign ptr_q = '0;
  end

  always_comb begin
    way_match = '0;
    for (int w = 0; w < WAYS; w++)
      way_match[w] = rd_valid[w] && !way_bad[w] && (rd_tag[w] == tag_q);
  end

  // Descending scans so the lowest-numbered candidate is the last written.
  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    victim_way = '0;
    if (resp_q) begin
      hit        = |way_match;
      victim_way = ptr_q;
      for (int w = WAYS - 1; w >= 0; w--) begin
        if (way_match[w]) hit_way    = WWIDTH'(w);
        if (!rd_valid[w]) victim_way = WWIDTH'(w);
      end
    end
  end

  assign resp_valid = resp_q;

endmodule
